// File: rtl/dbf_apod_stage.sv
// Dynamic apodization for one DBF channel: scales each coarse-delayed sample
// by a depth-indexed Q1.15 weight from a local LUT, then rounds half toward
// +inf and saturates back to the channel sample width. The LUT is loaded from
// the shared configuration bus while the channel is idle.
module dbf_apod_stage #(
   parameter int INPUT_WD = 14,
   parameter int APO_WD   = 16,
   parameter int ADDR_WD  = 10,
   parameter int APO_FRAC = 15
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       tx_en,
   input  logic signed [INPUT_WD-1:0] din,
   input  logic                       din_valid,
   input  logic        [ADDR_WD-1:0]  lut_addr,
   input  logic                       lut_we,
   input  logic signed [APO_WD-1:0]   apo_din,
   input  logic        [ADDR_WD-1:0]  line_len,
   output logic signed [INPUT_WD-1:0] dout,
   output logic                       dout_valid,
   output logic                       line_done,
   output logic                       sat_flag
);

   localparam int PROD_W    = INPUT_WD + APO_WD;
   localparam int RND_W     = PROD_W + 1;
   localparam int LUT_DEPTH = 1 << ADDR_WD;

   localparam logic signed [RND_W-1:0]    HALF    = RND_W'(2 ** (APO_FRAC - 1));
   localparam logic signed [RND_W-1:0]    SAT_MAX = RND_W'((2 ** (INPUT_WD - 1)) - 1);
   localparam logic signed [RND_W-1:0]    SAT_MIN = ~SAT_MAX;
   localparam logic signed [INPUT_WD-1:0] OUT_MAX = {1'b0, {(INPUT_WD-1){1'b1}}};
   localparam logic signed [INPUT_WD-1:0] OUT_MIN = {1'b1, {(INPUT_WD-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                     state;
   logic        [ADDR_WD-1:0]  rd_cnt;
   logic        [ADDR_WD-1:0]  len_q;
   logic        [ADDR_WD-1:0]  last_idx;
   logic                       accept;
   logic                       flush;

   logic signed [APO_WD-1:0]   lut [LUT_DEPTH];

   logic signed [INPUT_WD-1:0] din_p0;
   logic signed [APO_WD-1:0]   w_p0;
   logic                       vld_p0;
   logic                       last_p0;
   logic signed [PROD_W-1:0]   prod_p1;
   logic                       vld_p1;
   logic                       last_p1;
   logic signed [RND_W-1:0]    rnd_p1;

   // Add half an LSB of the output scale, then drop the fractional bits.
   function automatic logic signed [RND_W-1:0] round_half_up(input logic signed [PROD_W-1:0] p);
      logic signed [RND_W-1:0] ext;
      ext = {p[PROD_W-1], p};
      return (ext + HALF) >>> APO_FRAC;
   endfunction

   function automatic logic is_sat(input logic signed [RND_W-1:0] r);
      return (r > SAT_MAX) || (r < SAT_MIN);
   endfunction

   function automatic logic signed [INPUT_WD-1:0] saturate(input logic signed [RND_W-1:0] r);
      if (r > SAT_MAX)      return OUT_MAX;
      else if (r < SAT_MIN) return OUT_MIN;
      else                  return r[INPUT_WD-1:0];
   endfunction

   // len_q == 0 wraps to the all-ones index, giving a full-depth line.
   assign last_idx = len_q - ADDR_WD'(1);
   assign accept   = (state == RUN) && start && din_valid && !tx_en;
   assign flush    = (state == RUN) && !start;
   assign rnd_p1   = round_half_up(prod_p1);

   // Weight LUT load port; only honoured while idle so reads never collide.
   always_ff @(posedge clk) begin
      if (lut_we && (state == IDLE))
         lut[lut_addr] <= apo_din;
   end

   // Datapath registers carry no reset; their qualifiers live in the control block.
   always_ff @(posedge clk) begin
      // stage p0: accepted sample and its weight
      if (accept) begin
         din_p0 <= din;
         w_p0   <= lut[rd_cnt];
      end
      // stage p1: full-precision product
      if (vld_p0)
         prod_p1 <= PROD_W'(din_p0) * PROD_W'(w_p0);
   end

   // Line FSM, valid pipeline and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rd_cnt     <= '0;
         len_q      <= '0;
         vld_p0     <= 1'b0;
         last_p0    <= 1'b0;
         vld_p1     <= 1'b0;
         last_p1    <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
         line_done  <= 1'b0;
         sat_flag   <= 1'b0;
      end else begin
         vld_p0     <= accept;
         last_p0    <= accept && (rd_cnt == last_idx);
         vld_p1     <= vld_p0;
         last_p1    <= last_p0;
         // stage p2: rounded, saturated output
         dout_valid <= vld_p1;
         line_done  <= vld_p1 && last_p1;
         if (vld_p1 && !flush) begin
            dout <= saturate(rnd_p1);
            if (is_sat(rnd_p1))
               sat_flag <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (start && !tx_en) begin
                  state    <= RUN;
                  rd_cnt   <= '0;
                  len_q    <= line_len;
                  sat_flag <= 1'b0;
               end
            end
            RUN: begin
               if (!start) begin
                  // abort: drop everything still in flight
                  state      <= IDLE;
                  vld_p0     <= 1'b0;
                  vld_p1     <= 1'b0;
                  dout_valid <= 1'b0;
                  line_done  <= 1'b0;
               end else if (accept) begin
                  rd_cnt <= rd_cnt + ADDR_WD'(1);
                  if (rd_cnt == last_idx)
                     state <= DONE;
               end
            end
            DONE: begin
               if (!start)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
